// File: rtl/mul_tree_bf16_param_pkg.sv
// Shared constants for the bf16 product tree and its leaf multiplier.
package mul_tree_bf16_param_pkg;

  localparam logic [15:0] BF16_ONE  = 16'h3F80;
  localparam logic [15:0] BF16_QNAN = 16'h7FC0;

  localparam int MUL3_LAT    = 3;
  localparam int DEF_NUM_IN  = 8;
  localparam int DEF_DW      = 16;
  localparam int DEF_MUL_LAT = MUL3_LAT;

endpackage

// File: rtl/mul_tree_bf16_param_mul.sv
// Three-stage bf16 multiplier: unpack/classify, mantissa product, normalise/round.
// Denormal inputs and results flush to signed zero; rounding is nearest-even.
module mul_3_stage_pipe_bf16
  import mul_tree_bf16_param_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_mul,
  input  logic        input_mul_stb,
  output logic [15:0] output_mul,
  output logic        output_mul_stb
);

  logic [15:0] w_a, w_b;
  logic        w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;

  assign w_a = input_mul[31:16];
  assign w_b = input_mul[15:0];

  always_comb begin
    w_a_zero = (w_a[14:7] == 8'h00);
    w_a_inf  = (w_a[14:7] == 8'hFF) && (w_a[6:0] == 7'h00);
    w_a_nan  = (w_a[14:7] == 8'hFF) && (w_a[6:0] != 7'h00);
    w_b_zero = (w_b[14:7] == 8'h00);
    w_b_inf  = (w_b[14:7] == 8'hFF) && (w_b[6:0] == 7'h00);
    w_b_nan  = (w_b[14:7] == 8'hFF) && (w_b[6:0] != 7'h00);
  end

  logic       r1_vld, r1_sign, r1_nan, r1_inf, r1_zero;
  logic [7:0] r1_ea, r1_eb, r1_ma, r1_mb;

  always_ff @(posedge clk) begin
    if (rst) r1_vld <= 1'b0;
    else     r1_vld <= input_mul_stb;
    r1_sign <= w_a[15] ^ w_b[15];
    r1_ea   <= w_a[14:7];
    r1_eb   <= w_b[14:7];
    r1_ma   <= {1'b1, w_a[6:0]};
    r1_mb   <= {1'b1, w_b[6:0]};
    r1_nan  <= w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
    r1_inf  <= w_a_inf | w_b_inf;
    r1_zero <= w_a_zero | w_b_zero;
  end

  logic              r2_vld, r2_sign, r2_nan, r2_inf, r2_zero;
  logic [15:0]       r2_prod;
  logic signed [9:0] r2_exp;

  always_ff @(posedge clk) begin
    if (rst) r2_vld <= 1'b0;
    else     r2_vld <= r1_vld;
    r2_sign <= r1_sign;
    r2_nan  <= r1_nan;
    r2_inf  <= r1_inf;
    r2_zero <= r1_zero;
    r2_prod <= 16'(r1_ma) * 16'(r1_mb);
    r2_exp  <= {2'b00, r1_ea} + {2'b00, r1_eb} - 10'd127;
  end

  logic [6:0]        w_man;
  logic [7:0]        w_man_r;
  logic              w_rnd;
  logic signed [9:0] w_e_norm, w_e_fin;
  logic [15:0]       w_res;

  // Product of two 1.x mantissas lies in [1,4): bit 15 set means shift by one.
  always_comb begin
    if (r2_prod[15]) begin
      w_man    = r2_prod[14:8];
      w_rnd    = r2_prod[7] & ((|r2_prod[6:0]) | r2_prod[8]);
      w_e_norm = r2_exp + 10'sd1;
    end else begin
      w_man    = r2_prod[13:7];
      w_rnd    = r2_prod[6] & ((|r2_prod[5:0]) | r2_prod[7]);
      w_e_norm = r2_exp;
    end
    w_man_r = {1'b0, w_man} + {7'b0, w_rnd};
    w_e_fin = w_man_r[7] ? w_e_norm + 10'sd1 : w_e_norm;
    if (r2_nan)                  w_res = BF16_QNAN;
    else if (r2_inf)             w_res = {r2_sign, 8'hFF, 7'h00};
    else if (r2_zero)            w_res = {r2_sign, 15'h0000};
    else if (w_e_fin >= 10'sd255) w_res = {r2_sign, 8'hFF, 7'h00};
    else if (w_e_fin <= 10'sd0)   w_res = {r2_sign, 15'h0000};
    else                          w_res = {r2_sign, w_e_fin[7:0], w_man_r[6:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) output_mul_stb <= 1'b0;
    else     output_mul_stb <= r2_vld;
    output_mul <= w_res;
  end

endmodule

// File: rtl/mul_tree_bf16_param.sv
// Parameterised bf16 product tree: lanes are multiplied in groups of 2^mode with a
// fixed latency for every mode; lower-level results ride delay lines past unused levels.
module mul_tree_bf16_param
  import mul_tree_bf16_param_pkg::*;
#(
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int DW      = DEF_DW,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_IN*DW-1:0]                  mul_ins,
  input  logic                                  mul_stb,
  input  logic [$clog2($clog2(NUM_IN)+1)-1:0]   mode,
  input  logic [NUM_IN-1:0]                     in_mask,
  output logic [NUM_IN*DW-1:0]                  outputs,
  output logic                                  out_stb,
  output logic [$clog2($clog2(NUM_IN)+1)-1:0]   out_mode,
  output logic                                  busy
);

  localparam int LOG2N = $clog2(NUM_IN);
  localparam int MW    = $clog2(LOG2N + 1);
  localparam int L     = LOG2N * MUL_LAT + 1;
  localparam int CW    = $clog2(L + 1);

  logic [NUM_IN*DW-1:0] w_masked;
  logic [MW-1:0]        w_mode_clamp;

  always_comb begin
    w_masked = '0;
    for (int i = 0; i < NUM_IN; i++)
      w_masked[i*DW +: DW] = in_mask[i] ? mul_ins[i*DW +: DW] : DW'(BF16_ONE);
    w_mode_clamp = (int'(mode) > LOG2N) ? MW'(LOG2N) : mode;
  end

  logic [NUM_IN*DW-1:0] r_lane;
  logic [MW-1:0]        r_mode;
  logic                 r_vld;

  always_ff @(posedge clk) begin
    if (rst) r_vld <= 1'b0;
    else     r_vld <= mul_stb;
    r_lane <= w_masked;
    r_mode <= w_mode_clamp;
  end

  // Per level: zero-padded products, selected result, carried mode and valid.
  logic [NUM_IN*DW-1:0] w_prod [LOG2N+1];
  logic [NUM_IN*DW-1:0] w_res  [LOG2N+1];
  logic [MW-1:0]        w_mode [LOG2N+1];
  logic                 w_vld  [LOG2N+1];

  assign w_prod[0] = r_lane;
  assign w_res[0]  = (r_mode == '0) ? r_lane : '0;
  assign w_mode[0] = r_mode;
  assign w_vld[0]  = r_vld;

  genvar gi, gj;
  generate
    for (gi = 1; gi <= LOG2N; gi++) begin : g_lvl
      localparam int NG = NUM_IN >> gi;

      logic [NG-1:0]        w_stb;
      logic [NG*DW-1:0]     w_p;
      logic [MW-1:0]        r_mode_dly [MUL_LAT];
      logic [NUM_IN*DW-1:0] r_res_dly  [MUL_LAT];

      for (gj = 0; gj < NG; gj++) begin : g_mul
        mul_3_stage_pipe_bf16 u_mul (
          .clk            (clk),
          .rst            (rst),
          .input_mul      ({w_prod[gi-1][(2*gj)*DW +: DW], w_prod[gi-1][(2*gj+1)*DW +: DW]}),
          .input_mul_stb  (w_vld[gi-1]),
          .output_mul     (w_p[gj*DW +: DW]),
          .output_mul_stb (w_stb[gj])
        );
      end

      always_ff @(posedge clk) begin
        r_mode_dly[0] <= w_mode[gi-1];
        r_res_dly[0]  <= w_res[gi-1];
        for (int i = 1; i < MUL_LAT; i++) begin
          r_mode_dly[i] <= r_mode_dly[i-1];
          r_res_dly[i]  <= r_res_dly[i-1];
        end
      end

      assign w_prod[gi] = {{((NUM_IN - NG) * DW){1'b0}}, w_p};
      assign w_mode[gi] = r_mode_dly[MUL_LAT-1];
      assign w_vld[gi]  = &w_stb;
      assign w_res[gi]  = (w_mode[gi] == MW'(gi)) ? w_prod[gi] : r_res_dly[MUL_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_stb  <= 1'b0;
      outputs  <= '0;
      out_mode <= '0;
    end else begin
      out_stb <= w_vld[LOG2N];
      if (w_vld[LOG2N]) begin
        outputs  <= w_res[LOG2N];
        out_mode <= w_mode[LOG2N];
      end
    end
  end

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                     r_cnt <= '0;
    else if (mul_stb && !out_stb) r_cnt <= r_cnt + CW'(1);
    else if (!mul_stb && out_stb) r_cnt <= r_cnt - CW'(1);
  end

  assign busy = (r_cnt != '0);

endmodule

// File: tb/tb_mul_tree_bf16_param.sv
// Directed bench for mul_tree_bf16_param at NUM_IN=8, MUL_LAT=3 (latency 10).
module tb_mul_tree_bf16_param;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int MW = 2;
  localparam int VW = N * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [VW-1:0] mul_ins;
  logic          mul_stb;
  logic [MW-1:0] mode;
  logic [N-1:0]  in_mask;
  logic [VW-1:0] outputs;
  logic          out_stb;
  logic [MW-1:0] out_mode;
  logic          busy;

  int checks = 0;
  int errors = 0;

  mul_tree_bf16_param #(.NUM_IN(N), .DW(DW), .MUL_LAT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .mul_ins  (mul_ins),
    .mul_stb  (mul_stb),
    .mode     (mode),
    .in_mask  (in_mask),
    .outputs  (outputs),
    .out_stb  (out_stb),
    .out_mode (out_mode),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [VW-1:0] fill(input logic [DW-1:0] v, input int cnt);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < cnt; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic issue(input logic [MW-1:0] m, input logic [VW-1:0] vec, input logic [N-1:0] msk);
    @(negedge clk);
    mul_stb = 1'b1;
    mode    = m;
    mul_ins = vec;
    in_mask = msk;
  endtask

  task automatic idle();
    @(negedge clk);
    mul_stb = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_stb !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run1(input string tag, input logic [MW-1:0] m, input logic [VW-1:0] vec,
                      input logic [N-1:0] msk, input logic [VW-1:0] expv, input logic [MW-1:0] expm);
    int lat;
    issue(m, vec, msk);
    idle();
    wait_out(lat);
    chk({tag, " latency"}, VW'(lat), VW'(10));
    chk({tag, " outputs"}, outputs, expv);
    chk({tag, " out_mode"}, VW'(out_mode), VW'(expm));
    $display("txn %s mode=%0d latency=%0d out_mode=%0d outputs=%h", tag, m, lat, out_mode, outputs);
    @(negedge clk);
    chk({tag, " out_stb drop"}, VW'(out_stb), VW'(1'b0));
    chk({tag, " outputs held"}, outputs, expv);
    chk({tag, " busy idle"}, VW'(busy), VW'(1'b0));
  endtask

  logic [VW-1:0] two_all, three_all, seq_vec;
  logic [2:0]    m7;
  int            lat2, stb_seen;

  initial begin
    two_all   = fill(16'h4000, N);
    three_all = fill(16'h4040, N);
    seq_vec   = {16'h4100, 16'h4080, 16'h4060, 16'h4040, 16'h4020, 16'h4000, 16'h3FC0, 16'h3F80};
    m7        = 3'd7;

    rst = 1'b1; mul_stb = 1'b0; mode = '0; mul_ins = '0; in_mask = '0;
    repeat (3) @(negedge clk);
    chk("reset out_stb", VW'(out_stb), VW'(1'b0));
    chk("reset busy", VW'(busy), VW'(1'b0));
    chk("reset outputs", outputs, '0);
    chk("reset out_mode", VW'(out_mode), VW'(2'd0));
    rst = 1'b0;
    @(negedge clk);

    run1("m1_two", 2'd1, two_all, 8'hFF, fill(16'h4080, 4), 2'd1);
    run1("m3_two", 2'd3, two_all, 8'hFF, fill(16'h4380, 1), 2'd3);
    run1("m2_three_mask0F", 2'd2, three_all, 8'h0F, {96'h0, 16'h3F80, 16'h42A2}, 2'd2);
    run1("m1_three_maskAA", 2'd1, three_all, 8'hAA, fill(16'h4040, 4), 2'd1);
    run1("m0_pass", 2'd0, seq_vec, 8'hFF, seq_vec, 2'd0);
    run1("m7_as_m3", m7[MW-1:0], two_all, 8'hFF, fill(16'h4380, 1), 2'd3);

    // Back-to-back modes 1 then 3.
    issue(2'd1, two_all, 8'hFF);
    issue(2'd3, two_all, 8'hFF);
    idle();
    wait_out(lat2);
    chk("b2b first latency", VW'(lat2), VW'(9));
    chk("b2b first outputs", outputs, fill(16'h4080, 4));
    chk("b2b first out_mode", VW'(out_mode), VW'(2'd1));
    $display("txn b2b_first mode=1 out_mode=%0d outputs=%h", out_mode, outputs);
    @(negedge clk);
    chk("b2b second out_stb", VW'(out_stb), VW'(1'b1));
    chk("b2b second outputs", outputs, fill(16'h4380, 1));
    chk("b2b second out_mode", VW'(out_mode), VW'(2'd3));
    chk("b2b second busy", VW'(busy), VW'(1'b1));
    $display("txn b2b_second mode=3 out_mode=%0d outputs=%h", out_mode, outputs);
    @(negedge clk);
    chk("b2b after out_stb", VW'(out_stb), VW'(1'b0));
    chk("b2b after busy", VW'(busy), VW'(1'b0));

    // Three transactions, reset at cycle 5 with mul_stb also high.
    issue(2'd1, two_all, 8'hFF);
    issue(2'd2, two_all, 8'hFF);
    issue(2'd3, two_all, 8'hFF);
    idle();
    @(negedge clk);
    chk("flush busy before reset", VW'(busy), VW'(1'b1));
    rst = 1'b1;
    mul_stb = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mul_stb = 1'b0;
    stb_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_stb === 1'b1) stb_seen++;
      chk("flush busy", VW'(busy), VW'(1'b0));
      chk("flush outputs", outputs, '0);
      @(negedge clk);
    end
    chk("flush out_stb count", VW'(stb_seen), VW'(0));
    chk("flush out_mode", VW'(out_mode), VW'(2'd0));
    $display("txn flush out_stb_seen=%0d busy=%0d", stb_seen, busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
